// File: rtl/sdram_arb_pkg.sv
// Shared types and constants for the SDRAM request arbiter: FSM encoding,
// grant kinds, read requester indices and default widths.
package sdram_arb_pkg;

  localparam int ADDR_W_DEF        = 24;
  localparam int LEN_W_DEF         = 10;
  localparam int MAX_WR_STREAK_DEF = 4;

  localparam int RD_VGA = 0;
  localparam int RD_VEC = 1;

  typedef enum logic [2:0] {
    IDLE,
    WR_REQ,
    WR_BUSY,
    RD_REQ,
    RD_BUSY
  } arb_state_e;

  typedef enum logic [1:0] {
    GNT_NONE,
    GNT_WR,
    GNT_RD
  } grant_e;

endpackage

// File: rtl/sdram_req_arbiter_if.sv
// Bundle of requester-side and controller-side signals around the arbiter.
// The slave modport is the arbiter's view; master is the surrounding logic.
interface sdram_req_arbiter_if #(
  parameter int ADDR_W = 24,
  parameter int LEN_W  = 10
);

  logic              init_done;
  logic              wr_req;
  logic              wr_urgent;
  logic [ADDR_W-1:0] wr_addr;
  logic              wr_done;
  logic [1:0]        rd_req;
  logic [ADDR_W-1:0] rd_addr0;
  logic [ADDR_W-1:0] rd_addr1;
  logic [LEN_W-1:0]  rd_len0;
  logic [LEN_W-1:0]  rd_len1;
  logic [1:0]        rd_done;
  logic              sdram_wr_req;
  logic [ADDR_W-1:0] sdram_wr_addr;
  logic              sdram_wr_ack;
  logic              sdram_rd_req;
  logic [ADDR_W-1:0] sdram_rd_addr;
  logic [LEN_W-1:0]  sdram_rd_burst;
  logic              sdram_rd_ack;
  logic              rd_sel;

  modport slave (
    input  init_done, wr_req, wr_urgent, wr_addr,
    input  rd_req, rd_addr0, rd_addr1, rd_len0, rd_len1,
    input  sdram_wr_ack, sdram_rd_ack,
    output wr_done, rd_done,
    output sdram_wr_req, sdram_wr_addr,
    output sdram_rd_req, sdram_rd_addr, sdram_rd_burst, rd_sel
  );

  modport master (
    output init_done, wr_req, wr_urgent, wr_addr,
    output rd_req, rd_addr0, rd_addr1, rd_len0, rd_len1,
    output sdram_wr_ack, sdram_rd_ack,
    input  wr_done, rd_done,
    input  sdram_wr_req, sdram_wr_addr,
    input  sdram_rd_req, sdram_rd_addr, sdram_rd_burst, rd_sel
  );

endinterface

// File: rtl/sdram_arb_pick.sv
// Combinational grant selector: urgent write > reads (round-robin) > plain
// write, with an override that forces a pending read through.
module sdram_arb_pick
  import sdram_arb_pkg::*;
(
  input  logic       wr_req,
  input  logic       wr_urgent,
  input  logic [1:0] rd_req,
  input  logic       rr_ptr,
  input  logic       force_rd,
  output grant_e     grant,
  output logic       rd_idx
);

  logic rd_any;

  assign rd_any = |rd_req;

  // NOTE: every output gets a default first so no path through the
  // conditions leaves a value unassigned and infers a latch.
  always_comb begin
    grant  = GNT_NONE;
    rd_idx = rd_req[RD_VEC];
    if (rd_req == 2'b11) rd_idx = rr_ptr;

    if (rd_any && force_rd)         grant = GNT_RD;
    else if (wr_req && wr_urgent)   grant = GNT_WR;
    else if (rd_any)                grant = GNT_RD;
    else if (wr_req)                grant = GNT_WR;
  end

endmodule

// File: rtl/sdram_req_arbiter.sv
// Shares one SDRAM controller request port between a write requester and two
// read requesters. Optional read-starvation guard: SDRAM_ARB_STARVE_GUARD_EN.
module sdram_req_arbiter
  import sdram_arb_pkg::*;
#(
  parameter int ADDR_W        = ADDR_W_DEF,
  parameter int LEN_W         = LEN_W_DEF,
  parameter int MAX_WR_STREAK = MAX_WR_STREAK_DEF
) (
  input logic               clk,
  input logic               rst_n,
  sdram_req_arbiter_if.slave bus
);

  arb_state_e        state_q, state_d;
  grant_e            grant;
  logic              rd_idx;
  logic              rr_ptr_q;
  logic              force_rd;
  logic              take_wr, take_rd;
  logic              wr_done_d, wr_done_q;
  logic [1:0]        rd_done_d, rd_done_q;
  logic [ADDR_W-1:0] wr_addr_q, rd_addr_q;
  logic [LEN_W-1:0]  rd_len_q;
  logic              rd_sel_q;

  assign take_wr = (state_q == IDLE) && bus.init_done && (grant == GNT_WR);
  assign take_rd = (state_q == IDLE) && bus.init_done && (grant == GNT_RD);

`ifdef SDRAM_ARB_STARVE_GUARD_EN
  localparam int STREAK_W = $clog2(MAX_WR_STREAK + 1);

  logic [STREAK_W-1:0] streak_q;

  assign force_rd = (streak_q >= STREAK_W'(MAX_WR_STREAK));

  // Counts urgent writes that jumped ahead of a waiting read.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      streak_q <= '0;
    end else if (take_rd || (bus.rd_req == 2'b00)) begin
      streak_q <= '0;
    end else if (take_wr && bus.wr_urgent && !force_rd) begin
      streak_q <= streak_q + 1'b1;
    end
  end
`else
  assign force_rd = 1'b0;
`endif

  sdram_arb_pick u_pick (
    .wr_req    (bus.wr_req),
    .wr_urgent (bus.wr_urgent),
    .rd_req    (bus.rd_req),
    .rr_ptr    (rr_ptr_q),
    .force_rd  (force_rd),
    .grant     (grant),
    .rd_idx    (rd_idx)
  );

  always_comb begin
    state_d   = state_q;
    wr_done_d = 1'b0;
    rd_done_d = 2'b00;
    unique case (state_q)
      IDLE: begin
        if (take_wr)      state_d = WR_REQ;
        else if (take_rd) state_d = RD_REQ;
      end
      // An ack of the other type, or both acks at once, is not a valid reply.
      WR_REQ:  if (bus.sdram_wr_ack && !bus.sdram_rd_ack) state_d = WR_BUSY;
      RD_REQ:  if (bus.sdram_rd_ack && !bus.sdram_wr_ack) state_d = RD_BUSY;
      WR_BUSY: begin
        if (!bus.sdram_wr_ack) begin
          state_d   = IDLE;
          wr_done_d = 1'b1;
        end
      end
      RD_BUSY: begin
        if (!bus.sdram_rd_ack) begin
          state_d             = IDLE;
          rd_done_d[rd_sel_q] = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    // NOTE: control and datapath registers are all reset so outputs are
    // defined zeros right after reset, even when reset lands mid-burst.
    if (!rst_n) begin
      state_q   <= IDLE;
      rr_ptr_q  <= 1'b0;
      wr_done_q <= 1'b0;
      rd_done_q <= 2'b00;
      wr_addr_q <= '0;
      rd_addr_q <= '0;
      rd_len_q  <= '0;
      rd_sel_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      wr_done_q <= wr_done_d;
      rd_done_q <= rd_done_d;
      if (take_wr) wr_addr_q <= bus.wr_addr;
      if (take_rd) begin
        rd_sel_q  <= rd_idx;
        rd_addr_q <= (rd_idx == 1'(RD_VEC)) ? bus.rd_addr1 : bus.rd_addr0;
        rd_len_q  <= (rd_idx == 1'(RD_VEC)) ? bus.rd_len1  : bus.rd_len0;
        rr_ptr_q  <= ~rr_ptr_q;
      end
    end
  end

  assign bus.sdram_wr_req   = (state_q == WR_REQ);
  assign bus.sdram_rd_req   = (state_q == RD_REQ);
  assign bus.sdram_wr_addr  = wr_addr_q;
  assign bus.sdram_rd_addr  = rd_addr_q;
  assign bus.sdram_rd_burst = rd_len_q;
  assign bus.rd_sel         = rd_sel_q;
  assign bus.wr_done        = wr_done_q;
  assign bus.rd_done        = rd_done_q;

endmodule

// File: tb/tb_sdram_req_arbiter.sv
// Directed bench for sdram_req_arbiter; the bench plays both the requesters
// and the SDRAM controller, driving and sampling on the falling clock edge.
module tb_sdram_req_arbiter;

  localparam int ADDR_W = 24;
  localparam int LEN_W  = 10;

  logic clk;
  logic rst_n;
  int   tests;
  int   failed;

  sdram_req_arbiter_if #(.ADDR_W(ADDR_W), .LEN_W(LEN_W)) bus ();

  sdram_req_arbiter #(
    .ADDR_W        (ADDR_W),
    .LEN_W         (LEN_W),
    .MAX_WR_STREAK (4)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Called with the request visible; returns at the negedge where done shows.
  task automatic serve(input bit is_wr, input int hi, input logic [1:0] exp_rd_done);
    if (is_wr) bus.sdram_wr_ack = 1'b1;
    else       bus.sdram_rd_ack = 1'b1;
    @(negedge clk);
    check(is_wr ? "wr_req_drop" : "rd_req_drop",
          is_wr ? 32'(bus.sdram_wr_req) : 32'(bus.sdram_rd_req), 0);
    repeat (hi - 1) @(negedge clk);
    bus.sdram_wr_ack = 1'b0;
    bus.sdram_rd_ack = 1'b0;
    @(negedge clk);
    check("done_wr", 32'(bus.wr_done), 32'(is_wr));
    check("done_rd", 32'(bus.rd_done), 32'(is_wr ? 2'b00 : exp_rd_done));
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_wr_req"}, 32'(bus.sdram_wr_req), 0);
    check({tag, "_rd_req"}, 32'(bus.sdram_rd_req), 0);
    check({tag, "_wr_addr"}, 32'(bus.sdram_wr_addr), 0);
    check({tag, "_rd_addr"}, 32'(bus.sdram_rd_addr), 0);
    check({tag, "_burst"}, 32'(bus.sdram_rd_burst), 0);
    check({tag, "_rd_sel"}, 32'(bus.rd_sel), 0);
    check({tag, "_wr_done"}, 32'(bus.wr_done), 0);
    check({tag, "_rd_done"}, 32'(bus.rd_done), 0);
  endtask

  initial begin
    tests  = 0;
    failed = 0;
    rst_n  = 1'b0;
    bus.init_done    = 1'b0;
    bus.wr_req       = 1'b0;
    bus.wr_urgent    = 1'b0;
    bus.wr_addr      = '0;
    bus.rd_req       = 2'b00;
    bus.rd_addr0     = 24'h002000;
    bus.rd_addr1     = 24'h003000;
    bus.rd_len0      = 10'd256;
    bus.rd_len1      = 10'd128;
    bus.sdram_wr_ack = 1'b0;
    bus.sdram_rd_ack = 1'b0;

    // Reset state
    repeat (2) @(negedge clk);
    check_idle_outputs("rst");
    rst_n = 1'b1;
    bus.init_done = 1'b1;
    @(negedge clk);
    check("idle_wr_req", 32'(bus.sdram_wr_req), 0);

    // Single write, ack held 8 cycles, requester moves its address mid-burst
    bus.wr_req  = 1'b1;
    bus.wr_addr = 24'h000100;
    @(negedge clk);
    check("w1_req", 32'(bus.sdram_wr_req), 1);
    check("w1_addr", 32'(bus.sdram_wr_addr), 32'h100);
    check("w1_no_rd", 32'(bus.sdram_rd_req), 0);
    bus.wr_addr = 24'h000abc;
    bus.sdram_wr_ack = 1'b1;
    @(negedge clk);
    check("w1_req_drop", 32'(bus.sdram_wr_req), 0);
    check("w1_addr_hold", 32'(bus.sdram_wr_addr), 32'h100);
    repeat (7) @(negedge clk);
    check("w1_no_early_done", 32'(bus.wr_done), 0);
    bus.sdram_wr_ack = 1'b0;
    @(negedge clk);
    check("w1_done", 32'(bus.wr_done), 1);
    check("w1_rd_done", 32'(bus.rd_done), 0);
    bus.wr_req = 1'b0;
    @(negedge clk);
    check("w1_done_pulse", 32'(bus.wr_done), 0);
    check("w1_idle", 32'(bus.sdram_wr_req), 0);

    // Round-robin reads with both requests held
    bus.rd_req = 2'b11;
    @(negedge clk);
    check("rr0_req", 32'(bus.sdram_rd_req), 1);
    check("rr0_sel", 32'(bus.rd_sel), 0);
    check("rr0_burst", 32'(bus.sdram_rd_burst), 256);
    check("rr0_addr", 32'(bus.sdram_rd_addr), 32'h2000);
    serve(1'b0, 4, 2'b01);
    @(negedge clk);
    check("rr1_req", 32'(bus.sdram_rd_req), 1);
    check("rr1_sel", 32'(bus.rd_sel), 1);
    check("rr1_burst", 32'(bus.sdram_rd_burst), 128);
    check("rr1_addr", 32'(bus.sdram_rd_addr), 32'h3000);
    serve(1'b0, 3, 2'b10);
    @(negedge clk);
    check("rr2_sel", 32'(bus.rd_sel), 0);
    check("rr2_burst", 32'(bus.sdram_rd_burst), 256);
    serve(1'b0, 2, 2'b01);
    bus.rd_req = 2'b00;
    @(negedge clk);
    check("rr_idle", 32'(bus.sdram_rd_req), 0);
    check("rr_sel_hold", 32'(bus.rd_sel), 0);

    // Urgent write beats a simultaneous read; stray acks are ignored
    bus.wr_req    = 1'b1;
    bus.wr_urgent = 1'b1;
    bus.wr_addr   = 24'h000400;
    bus.rd_req    = 2'b01;
    @(negedge clk);
    check("pri_wr_first", 32'(bus.sdram_wr_req), 1);
    check("pri_rd_wait", 32'(bus.sdram_rd_req), 0);
    bus.sdram_rd_ack = 1'b1;
    @(negedge clk);
    check("pri_wrong_ack", 32'(bus.sdram_wr_req), 1);
    bus.sdram_wr_ack = 1'b1;
    @(negedge clk);
    check("pri_both_ack", 32'(bus.sdram_wr_req), 1);
    bus.sdram_rd_ack = 1'b0;
    serve(1'b1, 2, 2'b00);
    bus.wr_req    = 1'b0;
    bus.wr_urgent = 1'b0;
    @(negedge clk);
    check("pri_rd_next", 32'(bus.sdram_rd_req), 1);
    check("pri_rd_sel", 32'(bus.rd_sel), 0);
    serve(1'b0, 2, 2'b01);
    bus.rd_req = 2'b00;
    @(negedge clk);

    // Urgent write always pending while a read waits
    bus.wr_req    = 1'b1;
    bus.wr_urgent = 1'b1;
    bus.rd_req    = 2'b01;
    for (int i = 0; i < 6; i++) begin
      bit exp_wr;
`ifdef SDRAM_ARB_STARVE_GUARD_EN
      exp_wr = (i != 4);
`else
      exp_wr = 1'b1;
`endif
      @(negedge clk);
      check($sformatf("streak%0d_wr", i), 32'(bus.sdram_wr_req), 32'(exp_wr));
      check($sformatf("streak%0d_rd", i), 32'(bus.sdram_rd_req), 32'(!exp_wr));
      serve(exp_wr, 1, exp_wr ? 2'b00 : 2'b01);
    end
    bus.wr_req    = 1'b0;
    bus.wr_urgent = 1'b0;
    bus.rd_req    = 2'b00;
    @(negedge clk);

    // init_done low blocks all grants
    bus.init_done = 1'b0;
    bus.wr_req    = 1'b1;
    bus.rd_req    = 2'b11;
    repeat (3) begin
      @(negedge clk);
      check("init_wr_block", 32'(bus.sdram_wr_req), 0);
      check("init_rd_block", 32'(bus.sdram_rd_req), 0);
    end
    bus.init_done = 1'b1;
    @(negedge clk);
    check("init_rd_grant", 32'(bus.sdram_rd_req), 1);
    check("init_wr_low", 32'(bus.sdram_wr_req), 0);

    // Reset asserted for one cycle during RD_BUSY
    bus.sdram_rd_ack = 1'b1;
    @(negedge clk);
    check("rst_busy", 32'(bus.sdram_rd_req), 0);
    rst_n = 1'b0;
    @(negedge clk);
    check_idle_outputs("rst_mid");
    rst_n = 1'b1;
    bus.sdram_rd_ack = 1'b0;
    @(negedge clk);
    check("rst_no_done", 32'(bus.rd_done), 0);
    check("rst_fresh_req", 32'(bus.sdram_rd_req), 1);
    check("rst_fresh_sel", 32'(bus.rd_sel), 0);
    check("rst_fresh_burst", 32'(bus.sdram_rd_burst), 256);
    serve(1'b0, 1, 2'b01);
    bus.wr_req = 1'b0;
    bus.rd_req = 2'b00;
    @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
